id_hazard_ctrl: RTL and testbench

Controls the IF/ID pipeline register of the pipelined RV32I core and detects decode-stage hazards. It holds the fetched instruction and PC for the decode stage, where the immediate generator and register file consume them. It stalls the front end on load-use hazards, freezes it on data-memory stalls, and squashes wrong-path instructions after a taken branch or jump. It also keeps saturating performance counters for stall cycles and flush events.

---
 rtl/id_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_id_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// IF/ID pipeline register with load-use stall, memory-freeze and branch-squash control.
// Also keeps saturating perf counters for load-use stall cycles and flush events.
module id_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PERF_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           IfInstr,
    input  logic [31:0]           IfPc,
    input  logic                  IfValid,
    input  logic                  ExMemRead,
    input  logic [4:0]            ExRd,
    input  logic                  ExValid,
    input  logic                  BranchTaken,
    input  logic                  MemStall,
    output logic [31:0]           IdInstr,
    output logic [31:0]           IdPc,
    output logic                  IdValid,
    output logic                  PcWrite,
    output logic                  IdExBubble,
    output logic [PERF_WIDTH-1:0] StallCycles,
    output logic [PERF_WIDTH-1:0] FlushCount
);

    localparam logic [0:0]            ST_RUN       = 1'b0;
    localparam logic [0:0]            ST_FLUSH     = 1'b1;
    localparam logic [31:0]           NOP          = 32'h0000_0013;
    localparam logic [3:0]            FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [PERF_WIDTH-1:0] PERF_ONE     = PERF_WIDTH'(1);
    localparam logic [PERF_WIDTH-1:0] PERF_MAX     = '1;

    logic [31:0]           id_instr_q;
    logic [31:0]           id_pc_q;
    logic                  id_valid_q;
    logic [PERF_WIDTH-1:0] stall_cnt_q;
    logic [PERF_WIDTH-1:0] flush_evt_q;
    logic [0:0]            state_q;
    logic [3:0]            flush_cnt_q;

    logic [4:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;

    assign opcode = id_instr_q[6:2];
    assign rs1    = id_instr_q[19:15];
    assign rs2    = id_instr_q[24:20];

    // Loads, OP-IMM, stores, OP, branches, JALR read rs1; stores, OP, branches read rs2.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            5'd0, 5'd4, 5'd25: uses_rs1 = 1'b1;
            5'd8, 5'd12, 5'd24: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_use = id_valid_q & ExValid & ExMemRead & (ExRd != 5'd0) &
                      ((uses_rs1 & (rs1 == ExRd)) | (uses_rs2 & (rs2 == ExRd)));

    always_comb begin
        PcWrite    = 1'b0;
        IdExBubble = 1'b0;
        if (!rst && !MemStall) begin
            if (BranchTaken) begin
                PcWrite    = 1'b1;
                IdExBubble = 1'b1;
            end else if (load_use) begin
                IdExBubble = 1'b1;
            end else begin
                PcWrite = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr_q  <= NOP;
            id_pc_q     <= 32'h0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_evt_q <= '0;
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
        end else if (!MemStall) begin
            if (BranchTaken) begin
                id_instr_q <= IfInstr;
                id_pc_q    <= IfPc;
                id_valid_q <= 1'b0;
                if (flush_evt_q != PERF_MAX) flush_evt_q <= flush_evt_q + PERF_ONE;
                if (FLUSH_CYCLES > 1) begin
                    state_q     <= ST_FLUSH;
                    flush_cnt_q <= FLUSH_RELOAD;
                end else begin
                    state_q     <= ST_RUN;
                    flush_cnt_q <= 4'd0;
                end
            end else if (load_use) begin
                if (stall_cnt_q != PERF_MAX) stall_cnt_q <= stall_cnt_q + PERF_ONE;
            end else begin
                id_instr_q <= IfInstr;
                id_pc_q    <= IfPc;
                if (state_q == ST_FLUSH) begin
                    // Redirected fetch not yet back: keep squashing.
                    id_valid_q  <= 1'b0;
                    flush_cnt_q <= flush_cnt_q - 4'd1;
                    if (flush_cnt_q == 4'd1) state_q <= ST_RUN;
                end else begin
                    id_valid_q <= IfValid;
                end
            end
        end
    end

    assign IdInstr     = id_instr_q;
    assign IdPc        = id_pc_q;
    assign IdValid     = id_valid_q;
    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_evt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three parameterisations share stimulus, each checked
// against a rule-level reference model.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IfInstr, IfPc;
    logic        IfValid, ExMemRead, ExValid, BranchTaken, MemStall;
    logic [4:0]  ExRd;

    logic [31:0] id_instr [3];
    logic [31:0] id_pc    [3];
    logic        id_valid [3];
    logic        pc_write [3];
    logic        bubble   [3];
    logic [31:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.FLUSH_CYCLES(1), .PERF_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .IfInstr(IfInstr), .IfPc(IfPc), .IfValid(IfValid),
        .ExMemRead(ExMemRead), .ExRd(ExRd), .ExValid(ExValid), .BranchTaken(BranchTaken),
        .MemStall(MemStall), .IdInstr(id_instr[0]), .IdPc(id_pc[0]), .IdValid(id_valid[0]),
        .PcWrite(pc_write[0]), .IdExBubble(bubble[0]), .StallCycles(sc0), .FlushCount(fc0));

    id_hazard_ctrl #(.FLUSH_CYCLES(3), .PERF_WIDTH(32)) u1 (
        .clk(clk), .rst(rst), .IfInstr(IfInstr), .IfPc(IfPc), .IfValid(IfValid),
        .ExMemRead(ExMemRead), .ExRd(ExRd), .ExValid(ExValid), .BranchTaken(BranchTaken),
        .MemStall(MemStall), .IdInstr(id_instr[1]), .IdPc(id_pc[1]), .IdValid(id_valid[1]),
        .PcWrite(pc_write[1]), .IdExBubble(bubble[1]), .StallCycles(sc1), .FlushCount(fc1));

    id_hazard_ctrl #(.FLUSH_CYCLES(15), .PERF_WIDTH(4)) u2 (
        .clk(clk), .rst(rst), .IfInstr(IfInstr), .IfPc(IfPc), .IfValid(IfValid),
        .ExMemRead(ExMemRead), .ExRd(ExRd), .ExValid(ExValid), .BranchTaken(BranchTaken),
        .MemStall(MemStall), .IdInstr(id_instr[2]), .IdPc(id_pc[2]), .IdValid(id_valid[2]),
        .PcWrite(pc_write[2]), .IdExBubble(bubble[2]), .StallCycles(sc2), .FlushCount(fc2));

    // Reference model state per instance.
    int unsigned     cfg_flush [3] = '{1, 3, 15};
    longint unsigned cfg_max   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    logic [31:0]     m_instr [3];
    logic [31:0]     m_pc    [3];
    bit              m_valid [3];
    longint unsigned m_stall [3];
    longint unsigned m_flush [3];
    int              m_squash [3];  // further advancing cycles still to be squashed

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [31:0] ins);
        return ins[6:2] inside {5'd0, 5'd4, 5'd8, 5'd12, 5'd24, 5'd25};
    endfunction

    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:2] inside {5'd8, 5'd12, 5'd24};
    endfunction

    function automatic bit model_lu(input int k);
        bit hit;
        hit = (reads_rs1(m_instr[k]) && m_instr[k][19:15] == ExRd) ||
              (reads_rs2(m_instr[k]) && m_instr[k][24:20] == ExRd);
        return m_valid[k] && ExValid && ExMemRead && ExRd != 0 && hit;
    endfunction

    function automatic logic [31:0] obs_sc(input int k);
        return (k == 0) ? sc0 : (k == 1) ? sc1 : {28'h0, sc2};
    endfunction

    function automatic logic [31:0] obs_fc(input int k);
        return (k == 0) ? fc0 : (k == 1) ? fc1 : {28'h0, fc2};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_instr[k] = 32'h13; m_pc[k] = 0; m_valid[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_squash[k] = 0;
        end
    endtask

    task automatic check_all(input string ph);
        bit exp_pw, exp_bb;
        for (int k = 0; k < 3; k++) begin
            if (rst)              begin exp_pw = 0; exp_bb = 0; end
            else if (MemStall)    begin exp_pw = 0; exp_bb = 0; end
            else if (BranchTaken) begin exp_pw = 1; exp_bb = 1; end
            else if (model_lu(k)) begin exp_pw = 0; exp_bb = 1; end
            else                  begin exp_pw = 1; exp_bb = 0; end
            chk($sformatf("%s u%0d IdInstr", ph, k), id_instr[k], m_instr[k]);
            chk($sformatf("%s u%0d IdPc", ph, k), id_pc[k], m_pc[k]);
            chk($sformatf("%s u%0d IdValid", ph, k), {31'h0, id_valid[k]}, {31'h0, m_valid[k]});
            chk($sformatf("%s u%0d PcWrite", ph, k), {31'h0, pc_write[k]}, {31'h0, exp_pw});
            chk($sformatf("%s u%0d IdExBubble", ph, k), {31'h0, bubble[k]}, {31'h0, exp_bb});
            chk($sformatf("%s u%0d StallCycles", ph, k), obs_sc(k), m_stall[k][31:0]);
            chk($sformatf("%s u%0d FlushCount", ph, k), obs_fc(k), m_flush[k][31:0]);
        end
    endtask

    // One clock: check at negedge, advance model across the posedge, return 1 time unit later.
    task automatic step(input string ph);
        logic [31:0] n_instr [3];
        logic [31:0] n_pc [3];
        bit n_valid [3];
        longint unsigned n_stall [3], n_flush [3];
        int n_sq [3];
        @(negedge clk);
        check_all(ph);
        for (int k = 0; k < 3; k++) begin
            n_instr[k] = m_instr[k]; n_pc[k] = m_pc[k]; n_valid[k] = m_valid[k];
            n_stall[k] = m_stall[k]; n_flush[k] = m_flush[k]; n_sq[k] = m_squash[k];
            if (MemStall) begin
            end else if (BranchTaken) begin
                n_instr[k] = IfInstr; n_pc[k] = IfPc; n_valid[k] = 0;
                n_flush[k] = (m_flush[k] == cfg_max[k]) ? m_flush[k] : m_flush[k] + 1;
                n_sq[k] = int'(cfg_flush[k]) - 1;
            end else if (model_lu(k)) begin
                n_stall[k] = (m_stall[k] == cfg_max[k]) ? m_stall[k] : m_stall[k] + 1;
            end else begin
                n_instr[k] = IfInstr; n_pc[k] = IfPc;
                if (m_squash[k] > 0) begin n_valid[k] = 0; n_sq[k] = m_squash[k] - 1; end
                else n_valid[k] = IfValid;
            end
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_instr = n_instr; m_pc = n_pc; m_valid = n_valid;
            m_stall = n_stall; m_flush = n_flush; m_squash = n_sq;
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input bit v, input bit mr, input logic [4:0] rd,
                         input bit ev, input bit br, input bit ms);
        IfInstr = ins; IfPc = IfPc + 4; IfValid = v; ExMemRead = mr; ExRd = rd;
        ExValid = ev; BranchTaken = br; MemStall = ms;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] ops [12] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd24, 5'd25,
                                 5'd3, 5'd5, 5'd13, 5'd27, 5'd28, 5'd30};
        logic [31:0] ins;
        ins = $urandom;
        ins[6:2]   = ops[$urandom_range(0, 11)];
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        rst = 1'b1; IfPc = 32'h0;
        drive(32'h13, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1 check_all("reset");
        step("reset_hold");
        rst = 1'b0;

        // Load-use on rs1=x5.
        drive(32'h0072_8333, 1, 0, 0, 0, 0, 0);
        step("fill_add");
        drive(32'h0000_0013, 1, 1, 5'd5, 1, 0, 0);
        #1;
        chk("lu PcWrite", {31'h0, pc_write[0]}, 32'h0);
        chk("lu IdExBubble", {31'h0, bubble[0]}, 32'h1);
        step("loaduse");
        chk("lu held instr", id_instr[0], 32'h0072_8333);
        chk("lu StallCycles", sc0, 32'd1);
        ExMemRead = 1'b0;
        step("lu_release");
        chk("lu advanced", id_instr[0], 32'h0000_0013);

        // No false hazards: x0 source with ExRd=0, LUI field match, non-load match.
        drive(32'h0070_0333, 1, 0, 0, 1, 0, 0);
        step("fill_x0");
        drive(32'h1234_52B7, 1, 1, 5'd0, 1, 0, 0);
        #1 chk("x0 no stall", {31'h0, pc_write[0]}, 32'h1);
        step("x0");
        drive(32'h0072_8333, 1, 1, 5'd8, 1, 0, 0);
        #1 chk("lui no stall", {31'h0, pc_write[0]}, 32'h1);
        step("lui");
        drive(32'h0072_8333, 1, 0, 5'd5, 1, 0, 0);
        #1 chk("nonload no stall", {31'h0, bubble[0]}, 32'h0);
        step("nonload");

        // Branch flush.
        drive(32'hDEAD_0013, 1, 0, 0, 0, 1, 0);
        step("branch");
        chk("br1 IdValid", {31'h0, id_valid[0]}, 32'h0);
        chk("br1 FlushCount", fc0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("br3 squash %0d", i), {31'h0, id_valid[1]}, 32'h0);
            drive(32'h0000_0013, 1, 0, 0, 0, 0, 0);
            step("squash");
            if (i == 0) chk("br1 resumes", {31'h0, id_valid[0]}, 32'h1);
        end
        chk("br3 resumes", {31'h0, id_valid[1]}, 32'h1);

        // MemStall freezes everything even with branch and load-use present.
        drive(32'h0072_8333, 1, 0, 0, 0, 0, 0);
        step("fill_ms");
        drive(32'h0000_0013, 1, 1, 5'd7, 1, 1, 1);
        #1;
        chk("ms PcWrite", {31'h0, pc_write[0]}, 32'h0);
        chk("ms IdExBubble", {31'h0, bubble[0]}, 32'h0);
        step("memstall");
        step("memstall2");
        chk("ms FlushCount", fc0, 32'd1);
        MemStall = 1'b0;
        step("ms_release");
        chk("ms flush done", fc0, 32'd2);

        // Async reset mid-flush, between edges.
        drive(32'h0000_0013, 1, 0, 0, 0, 1, 0);
        step("br_pre_rst");
        BranchTaken = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst_flush");
        step("rst_hold");
        rst = 1'b0;

        // Async reset mid-stall.
        drive(32'h0072_8333, 1, 0, 0, 0, 0, 0);
        step("fill_rs");
        drive(32'h0000_0013, 1, 1, 5'd7, 1, 0, 0);
        step("stall_pre_rst");
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst_stall");
        chk("async IdInstr", id_instr[2], 32'h0000_0013);
        step("rst_hold2");
        rst = 1'b0;

        // Saturation of the 4-bit counter.
        drive(32'h0072_8333, 1, 0, 0, 0, 0, 0);
        step("fill_sat");
        drive(32'h0000_0013, 1, 1, 5'd5, 1, 0, 0);
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat StallCycles u2", {28'h0, sc2}, 32'd15);
        chk("sat StallCycles u0", sc0, 32'd20);
        for (int i = 0; i < 18; i++) begin
            drive(32'h0000_0013, 1, 0, 0, 0, 1, 0);
            step("flush_sat");
        end
        chk("sat FlushCount u2", {28'h0, fc2}, 32'd15);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(rand_instr(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
